mips_core: RTL and testbench

- Single-cycle 32-bit MIPS-I integer core executing a subset of the ISA.
- Instruction fetch and data access go to external memories through separate ports:
  - instruction reads are combinational;
  - data writes commit on the clock edge.
- The register file is instantiated as `regs`, with storage array `data[0:31]`. Benches probe this path hierarchically (e.g. `regs.data[2]`).

---
 rtl/mips_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mips_core.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_core.sv
// mips_core: single-cycle 32-bit MIPS-I integer core (subset).
// Every rising clock edge retires the instruction presented on instr_in.
// There is no branch delay slot. Unknown encodings execute as NOPs.
//
// Ports:
//   clk        - clock, rising edge only
//   reset      - synchronous, active-high; loads the PC and register file
//   instr_addr - current PC
//   instr_in   - instruction at instr_addr, combinational fetch
//   data_addr  - load/store effective address, rs + sext(imm16)
//   data_in    - load data, valid in the same cycle as data_addr
//   data_out   - store data, the rt value
//   data_rd_wr - 1 = read/idle, 0 = write; low only for SW outside reset
//
// mips_regfile: 32 x 32 register file with two combinational read ports
// and one synchronous write port. $0 reads as zero and ignores writes.
// Reset loads $sp and $ra with their start values and clears the rest.

module mips_regfile #(
    parameter logic [31:0] sp_init = 32'h80120000,
    parameter logic [31:0] ra_init = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] data [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                data[i] <= 32'h0;
            end
            data[29] <= sp_init;
            data[31] <= ra_init;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            data[wr_addr] <= wr_data;
        end
    end

    // Reads return the pre-edge contents; a write lands on the clock edge.
    assign rs_data = (rs_addr == 5'd0) ? 32'h0 : data[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'h0 : data[rt_addr];

endmodule

module mips_core #(
    parameter logic [31:0] pc_init = 32'h80020000,
    parameter logic [31:0] sp_init = 32'h80120000,
    parameter logic [31:0] ra_init = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_in,
    output logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_rd_wr
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    logic [31:0]        rs_data;
    logic [31:0]        rt_data;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic signed [31:0] imm_s;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        is_sw;

    assign opcode = instr_in[31:26];
    assign rs     = instr_in[25:21];
    assign rt     = instr_in[20:16];
    assign rd     = instr_in[15:11];
    assign shamt  = instr_in[10:6];
    assign funct  = instr_in[5:0];
    assign imm    = instr_in[15:0];

    assign pc_plus4   = pc + 32'd4;
    assign imm_sext   = {{16{imm[15]}}, imm};
    assign imm_zext   = {16'h0, imm};
    assign br_target  = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], instr_in[25:0], 2'b00};

    assign rs_s  = rs_data;
    assign rt_s  = rt_data;
    assign imm_s = imm_sext;

    mips_regfile #(
        .sp_init (sp_init),
        .ra_init (ra_init)
    ) regs (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Decode and execute: one combinational pass produces the register
    // write, the store strobe and the next PC for this edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = rt;
        wr_data = 32'h0;
        next_pc = pc_plus4;
        is_sw   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_en   = 1'b1;
                wr_addr = rd;
                case (funct)
                    F_SLL:  wr_data = rt_data << shamt;
                    F_SRL:  wr_data = rt_data >> shamt;
                    F_SRA:  wr_data = rt_s >>> shamt;
                    F_SLLV: wr_data = rt_data << rs_data[4:0];
                    F_SRLV: wr_data = rt_data >> rs_data[4:0];
                    F_SRAV: wr_data = rt_s >>> rs_data[4:0];
                    F_JR: begin
                        wr_en   = 1'b0;
                        next_pc = rs_data;
                    end
                    F_JALR: begin
                        wr_data = pc_plus4;
                        next_pc = rs_data;
                    end
                    // ADD/SUB never trap, so they share the wrap-around path.
                    F_ADD, F_ADDU: wr_data = rs_data + rt_data;
                    F_SUB, F_SUBU: wr_data = rs_data - rt_data;
                    F_AND:  wr_data = rs_data & rt_data;
                    F_OR:   wr_data = rs_data | rt_data;
                    F_XOR:  wr_data = rs_data ^ rt_data;
                    F_NOR:  wr_data = ~(rs_data | rt_data);
                    F_SLT:  wr_data = {31'h0, rs_s < rt_s};
                    F_SLTU: wr_data = {31'h0, rs_data < rt_data};
                    default: wr_en = 1'b0;
                endcase
            end
            OP_J: next_pc = jmp_target;
            OP_JAL: begin
                wr_en   = 1'b1;
                wr_addr = 5'd31;
                wr_data = pc_plus4;
                next_pc = jmp_target;
            end
            OP_BEQ:  if (rs_data == rt_data) next_pc = br_target;
            OP_BNE:  if (rs_data != rt_data) next_pc = br_target;
            OP_BLEZ: if (rs_s <= 32'sd0) next_pc = br_target;
            OP_BGTZ: if (rs_s > 32'sd0) next_pc = br_target;
            OP_ADDI, OP_ADDIU: begin
                wr_en   = 1'b1;
                wr_data = rs_data + imm_sext;
            end
            OP_SLTI: begin
                wr_en   = 1'b1;
                wr_data = {31'h0, rs_s < imm_s};
            end
            // The immediate is sign-extended first, then compared unsigned.
            OP_SLTIU: begin
                wr_en   = 1'b1;
                wr_data = {31'h0, rs_data < imm_sext};
            end
            OP_ANDI: begin
                wr_en   = 1'b1;
                wr_data = rs_data & imm_zext;
            end
            OP_ORI: begin
                wr_en   = 1'b1;
                wr_data = rs_data | imm_zext;
            end
            OP_XORI: begin
                wr_en   = 1'b1;
                wr_data = rs_data ^ imm_zext;
            end
            OP_LUI: begin
                wr_en   = 1'b1;
                wr_data = {imm, 16'h0};
            end
            OP_LW: begin
                wr_en   = 1'b1;
                wr_data = data_in;
            end
            OP_SW: is_sw = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= pc_init;
        end else begin
            pc <= next_pc;
        end
    end

    assign instr_addr = pc;
    assign data_addr  = rs_data + imm_sext;
    assign data_out   = rt_data;
    // A store in flight while reset is high must not reach memory.
    assign data_rd_wr = ~(is_sw & ~reset);

endmodule

// File: tb/tb_mips_core.sv
module tb_mips_core;

    localparam logic [31:0] BASE = 32'h80020000;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_rd_wr;

    logic [31:0] prog [0:31];
    logic [31:0] dmem [0:15] = '{default: 32'h0};

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] obs [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    mips_core dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr_in   (instr_in),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_rd_wr (data_rd_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory window at BASE; everything else fetches a NOP.
    assign instr_in = (instr_addr[31:7] == BASE[31:7]) ? prog[instr_addr[6:2]] : 32'h0;
    assign data_in  = dmem[data_addr[5:2]];

    always @(posedge clk) begin
        if (data_rd_wr == 1'b0) dmem[data_addr[5:2]] <= data_out;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic load_prog(input logic [31:0] words [$]);
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        for (int i = 0; i < words.size(); i++) prog[i] = words[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] words [$];
        logic        others_ok;
        words = '{enc_i(6'h2b, 5'd0, 5'd2, 16'h0)};
        load_prog(words);
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_val("rst_rd_wr_forced", 32'h1);
        obs.push_back({31'h0, data_rd_wr});
        @(negedge clk);
        expect_val("rst_pc", BASE);
        obs.push_back(instr_addr);
        expect_val("rst_sp", 32'h80120000);
        obs.push_back(dut.regs.data[29]);
        expect_val("rst_ra", 32'h0);
        obs.push_back(dut.regs.data[31]);
        others_ok = 1'b1;
        for (int i = 0; i < 29; i++) if (dut.regs.data[i] !== 32'h0) others_ok = 1'b0;
        if (dut.regs.data[30] !== 32'h0) others_ok = 1'b0;
        expect_val("rst_other_regs_zero", 32'h1);
        obs.push_back({31'h0, others_ok});
        reset = 1'b0;
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_arith();
        logic [31:0] words [$];
        words = '{enc_i(6'h09, 5'd0, 5'd2, 16'd5),
                  enc_i(6'h09, 5'd0, 5'd3, 16'hFFFD),
                  enc_r(5'd2, 5'd3, 5'd2, 5'd0, 6'h21),
                  enc_r(5'd3, 5'd2, 5'd3, 5'd0, 6'h2a)};
        load_prog(words);
        do_reset();
        expect_val("arith_pc0", BASE);
        obs.push_back(instr_addr);
        step(1);
        expect_val("arith_pc1", BASE + 32'd4);
        obs.push_back(instr_addr);
        step(1);
        expect_val("arith_pc2", BASE + 32'd8);
        obs.push_back(instr_addr);
        expect_val("arith_r2_a", 32'd5);
        obs.push_back(dut.regs.data[2]);
        expect_val("arith_r3_a", 32'hFFFFFFFD);
        obs.push_back(dut.regs.data[3]);
        step(2);
        expect_val("arith_pc4", BASE + 32'h10);
        obs.push_back(instr_addr);
        expect_val("arith_addu", 32'd2);
        obs.push_back(dut.regs.data[2]);
        expect_val("arith_slt", 32'd1);
        obs.push_back(dut.regs.data[3]);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_load_store();
        logic [31:0] words [$];
        words = '{enc_i(6'h0f, 5'd0, 5'd2, 16'hCAFE),
                  enc_i(6'h0d, 5'd2, 5'd2, 16'hBABE),
                  enc_i(6'h0f, 5'd0, 5'd4, 16'h8003),
                  enc_i(6'h2b, 5'd4, 5'd2, 16'd4),
                  enc_i(6'h23, 5'd4, 5'd3, 16'd4)};
        load_prog(words);
        do_reset();
        expect_val("ls_idle_rd_wr", 32'h1);
        obs.push_back({31'h0, data_rd_wr});
        step(3);
        expect_val("ls_sw_rd_wr", 32'h0);
        obs.push_back({31'h0, data_rd_wr});
        expect_val("ls_sw_addr", 32'h80030004);
        obs.push_back(data_addr);
        expect_val("ls_sw_data", 32'hCAFEBABE);
        obs.push_back(data_out);
        step(1);
        expect_val("ls_lw_rd_wr", 32'h1);
        obs.push_back({31'h0, data_rd_wr});
        expect_val("ls_mem_word", 32'hCAFEBABE);
        obs.push_back(dmem[1]);
        step(1);
        expect_val("ls_lw_result", 32'hCAFEBABE);
        obs.push_back(dut.regs.data[3]);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_branches();
        logic [31:0] words [$];
        for (int i = 0; i < 22; i++) words.push_back(32'h0);
        words[0]  = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
        words[1]  = enc_i(6'h09, 5'd0, 5'd3, 16'd1);
        words[2]  = enc_i(6'h09, 5'd0, 5'd8, 16'd9);
        words[5]  = enc_i(6'h04, 5'd2, 5'd3, 16'd2);
        words[6]  = enc_i(6'h09, 5'd0, 5'd9, 16'h99);
        words[7]  = enc_i(6'h09, 5'd0, 5'd9, 16'h77);
        words[8]  = enc_i(6'h05, 5'd2, 5'd3, 16'd5);
        words[9]  = enc_j(6'h03, BASE + 32'h40);
        words[10] = enc_i(6'h09, 5'd0, 5'd10, 16'h42);
        words[11] = enc_j(6'h02, BASE + 32'h48);
        words[16] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        words[18] = enc_i(6'h07, 5'd2, 5'd0, 16'd1);
        words[20] = enc_i(6'h06, 5'd2, 5'd0, 16'd3);
        load_prog(words);
        do_reset();
        step(5);
        expect_val("br_pc_at_beq", BASE + 32'h14);
        obs.push_back(instr_addr);
        step(1);
        expect_val("br_beq_taken", BASE + 32'h20);
        obs.push_back(instr_addr);
        step(1);
        expect_val("br_bne_not_taken", BASE + 32'h24);
        obs.push_back(instr_addr);
        step(1);
        expect_val("br_jal_target", BASE + 32'h40);
        obs.push_back(instr_addr);
        expect_val("br_jal_link", BASE + 32'h28);
        obs.push_back(dut.regs.data[31]);
        step(1);
        expect_val("br_jr_return", BASE + 32'h28);
        obs.push_back(instr_addr);
        step(2);
        expect_val("br_after_return", 32'h42);
        obs.push_back(dut.regs.data[10]);
        expect_val("br_j_target", BASE + 32'h48);
        obs.push_back(instr_addr);
        step(1);
        expect_val("br_bgtz_taken", BASE + 32'h50);
        obs.push_back(instr_addr);
        step(1);
        expect_val("br_blez_not_taken", BASE + 32'h54);
        obs.push_back(instr_addr);
        expect_val("br_skipped_slot", 32'h0);
        obs.push_back(dut.regs.data[9]);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_end();
        logic [31:0] words [$];
        words = '{enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08)};
        load_prog(words);
        do_reset();
        step(1);
        expect_val("end_pc_zero", 32'h0);
        obs.push_back(instr_addr);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_logic();
        logic [31:0] words [$];
        words = '{enc_i(6'h0d, 5'd0, 5'd0, 16'd7),
                  enc_i(6'h0f, 5'd0, 5'd5, 16'hFFFF),
                  enc_r(5'd0, 5'd5, 5'd6, 5'd4, 6'h03),
                  enc_r(5'd0, 5'd0, 5'd7, 5'd0, 6'h27),
                  enc_i(6'h0b, 5'd0, 5'd8, 16'hFFFF),
                  enc_r(5'd5, 5'd6, 5'd11, 5'd0, 6'h23)};
        load_prog(words);
        do_reset();
        step(6);
        expect_val("logic_r0_stays_zero", 32'h0);
        obs.push_back(dut.regs.data[0]);
        expect_val("logic_sra", 32'hFFFFF000);
        obs.push_back(dut.regs.data[6]);
        expect_val("logic_nor", 32'hFFFFFFFF);
        obs.push_back(dut.regs.data[7]);
        expect_val("logic_sltiu", 32'h1);
        obs.push_back(dut.regs.data[8]);
        expect_val("logic_subu_wrap", 32'hFFFF0000 - 32'hFFFFF000);
        obs.push_back(dut.regs.data[11]);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [31:0] words [$];
        words = '{enc_i(6'h0f, 5'd0, 5'd4, 16'h8003),
                  enc_i(6'h09, 5'd0, 5'd2, 16'h77),
                  enc_i(6'h2b, 5'd4, 5'd2, 16'd8)};
        load_prog(words);
        do_reset();
        step(2);
        expect_val("mid_sw_pending", 32'h0);
        obs.push_back({31'h0, data_rd_wr});
        reset = 1'b1;
        #1;
        expect_val("mid_sw_suppressed", 32'h1);
        obs.push_back({31'h0, data_rd_wr});
        @(negedge clk);
        reset = 1'b0;
        expect_val("mid_mem_untouched", 32'h0);
        obs.push_back(dmem[2]);
        expect_val("mid_pc_reloaded", BASE);
        obs.push_back(instr_addr);
        expect_val("mid_reg_cleared", 32'h0);
        obs.push_back(dut.regs.data[2]);
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] o = obs.pop_front();
            n_cmp++;
            if (o !== e.exp) begin
                $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
        test_reset();
        test_arith();
        test_load_store();
        test_branches();
        test_end();
        test_logic();
        test_reset_mid_sw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
